// File: rtl/memory_pkg.sv
// Shared types and constants for the r1/r2 mercury tank gating controllers.
// Combinational helper only; no latency, no backpressure.
package memory_pkg;

   localparam int DIGITS      = 18;
   localparam int MINORS      = 32;
   localparam int WORD_DIGITS = 17;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_XFER = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      WAIT = ST_WAIT,
      XFER = ST_XFER
   } state_e;

   typedef struct packed {
      logic       we;
      logic       long;
      logic [4:0] addr;
   } req_t;

   // A long word covers minor cycles addr and addr|1, including the spare
   // (sandwich) digit of the first one; a short word is digits 0..16 only.
   function automatic logic in_window(input req_t r, input logic [4:0] m, input logic [4:0] d);
      logic body;
      body = (d < 5'(WORD_DIGITS));
      if (r.long)
         return (m == r.addr) || ((m == {r.addr[4:1], 1'b1}) && body);
      return (m == r.addr) && body;
   endfunction

endpackage

// File: rtl/memory_tank_timer.sv
// Free-running digit/minor recirculation position counter; registered outputs plus next values.
// Never stalls; reset realigns the count with the delay-line stage.
module memory_tank_timer
   import memory_pkg::*;
#(
   parameter int DIGITS = memory_pkg::DIGITS,
   parameter int MINORS = memory_pkg::MINORS
) (
   input  logic       clk,
   input  logic       rst,
   output logic [4:0] digit,
   output logic [4:0] minor,
   output logic [4:0] digit_nxt,
   output logic [4:0] minor_nxt
);

   logic digit_wrap;

   always_comb begin
      digit_wrap = (digit == 5'(DIGITS - 1));
      digit_nxt  = digit_wrap ? 5'd0 : digit + 5'd1;
      minor_nxt  = minor;
      if (digit_wrap)
         minor_nxt = (minor == 5'(MINORS - 1)) ? 5'd0 : minor + 5'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         digit <= 5'd0;
         minor <= 5'd0;
      end else begin
         digit <= digit_nxt;
         minor <= minor_nxt;
      end
   end

endmodule

// File: rtl/memory_r1_up_tank_ctrl.sv
// r1 upper tank 0 gate controller: opens clr/in/out over the addressed word; 0..575 cycles wait, done after window.
// No backpressure: requests while busy are dropped, not queued.
module memory_r1_up_tank_ctrl
   import memory_pkg::*;
#(
   parameter int DIGITS = memory_pkg::DIGITS,
   parameter int MINORS = memory_pkg::MINORS
) (
   input  logic       r1_clk,
   input  logic       r1_rst,
   input  logic       r1_up_t0_req,
   input  logic       r1_up_t0_we,
   input  logic       r1_up_t0_long,
   input  logic [4:0] r1_up_t0_addr,
   output logic       r1_up_t0_clr,
   output logic       r1_up_t0_in,
   output logic       r1_up_t0_out,
   output logic       r1_up_t0_busy,
   output logic       r1_up_t0_done,
   output logic [4:0] r1_up_t0_minor,
   output logic [4:0] r1_up_t0_digit
);

   logic [4:0] digit_nxt;
   logic [4:0] minor_nxt;
   state_e     state;
   state_e     state_nxt;
   req_t       cur;
   req_t       cur_nxt;
   logic       gate_nxt;
   logic       done_nxt;

   memory_tank_timer #(
      .DIGITS(DIGITS),
      .MINORS(MINORS)
   ) u_timer (
      .clk      (r1_clk),
      .rst      (r1_rst),
      .digit    (r1_up_t0_digit),
      .minor    (r1_up_t0_minor),
      .digit_nxt(digit_nxt),
      .minor_nxt(minor_nxt)
   );

   // Decisions look at the next counter values so the gates are high in
   // exactly the cycles whose position lies inside the window.
   always_comb begin
      state_nxt = state;
      cur_nxt   = cur;
      gate_nxt  = 1'b0;
      done_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (r1_up_t0_req) begin
               cur_nxt.we   = r1_up_t0_we;
               cur_nxt.long = r1_up_t0_long;
               cur_nxt.addr = r1_up_t0_long ? {r1_up_t0_addr[4:1], 1'b0} : r1_up_t0_addr;
               state_nxt    = WAIT;
               if ((minor_nxt == cur_nxt.addr) && (digit_nxt == 5'd0)) begin
                  state_nxt = XFER;
                  gate_nxt  = 1'b1;
               end
            end
         end
         WAIT: begin
            if ((minor_nxt == cur.addr) && (digit_nxt == 5'd0)) begin
               state_nxt = XFER;
               gate_nxt  = 1'b1;
            end
         end
         XFER: begin
            if (in_window(cur, minor_nxt, digit_nxt)) begin
               gate_nxt = 1'b1;
            end else begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge r1_clk) begin
      if (r1_rst) begin
         state         <= IDLE;
         cur           <= '0;
         r1_up_t0_clr  <= 1'b0;
         r1_up_t0_in   <= 1'b0;
         r1_up_t0_out  <= 1'b0;
         r1_up_t0_done <= 1'b0;
      end else begin
         state         <= state_nxt;
         cur           <= cur_nxt;
         r1_up_t0_clr  <= gate_nxt & cur_nxt.we;
         r1_up_t0_in   <= gate_nxt & cur_nxt.we;
         r1_up_t0_out  <= gate_nxt & ~cur_nxt.we;
         r1_up_t0_done <= done_nxt;
      end
   end

   assign r1_up_t0_busy = (state != IDLE);

endmodule

// File: tb/tb_memory_r1_up_tank_ctrl.sv
// Bench for memory_r1_up_tank_ctrl: absolute-time window model feeding a scoreboard queue.
module tb_memory_r1_up_tank_ctrl;

   localparam int DIG  = 18;
   localparam int MIN  = 32;
   localparam int CIRC = DIG * MIN;

   logic       clk  = 1'b0;
   logic       rst  = 1'b1;
   logic       req  = 1'b0;
   logic       we   = 1'b0;
   logic       lng  = 1'b0;
   logic [4:0] addr = 5'd0;
   logic       clr, in_g, out_g, busy, done;
   logic [4:0] minor, digit;

   always #5 clk = ~clk;

   memory_r1_up_tank_ctrl dut (
      .r1_clk        (clk),
      .r1_rst        (rst),
      .r1_up_t0_req  (req),
      .r1_up_t0_we   (we),
      .r1_up_t0_long (lng),
      .r1_up_t0_addr (addr),
      .r1_up_t0_clr  (clr),
      .r1_up_t0_in   (in_g),
      .r1_up_t0_out  (out_g),
      .r1_up_t0_busy (busy),
      .r1_up_t0_done (done),
      .r1_up_t0_minor(minor),
      .r1_up_t0_digit(digit)
   );

   // One accepted transfer in absolute cycle numbers (cycle 0 = first after reset).
   typedef struct {
      bit we;
      int acc;
      int first;
      int len;
   } txn_t;

   txn_t sb[$];
   int   cyc       = 0;
   int   last_done = 0;
   int   n_chk     = 0;
   int   n_pass    = 0;
   bit   started   = 1'b0;

   always @(posedge clk) begin
      if (rst) cyc = 0;
      else     cyc = cyc + 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
   endtask

   // Monitor: compares every cycle, pops the scoreboard on each done pulse.
   always @(negedge clk) begin
      logic [2:0] eg;
      logic       eb;
      int         p;
      int         due;
      txn_t       t;
      if (started) begin
         eg = 3'b000;
         eb = 1'b0;
         if (sb.size() > 0) begin
            t  = sb[0];
            eb = (cyc > t.acc) && (cyc < t.first + t.len);
            if (cyc >= t.first && cyc < t.first + t.len)
               eg = t.we ? 3'b110 : 3'b001;
         end
         chk("gates", {29'd0, clr, in_g, out_g}, {29'd0, eg});
         chk("busy", {31'd0, busy}, {31'd0, eb});
         p = cyc % CIRC;
         chk("position", {22'd0, minor, digit}, ((p / DIG) << 5) | (p % DIG));
         if (done === 1'b1) begin
            if (sb.size() == 0) begin
               chk("done_unexpected", 32'd1, 32'd0);
            end else begin
               due = sb[0].first + sb[0].len;
               chk("done_time", cyc, due);
               void'(sb.pop_front());
            end
         end else if (sb.size() > 0) begin
            due = sb[0].first + sb[0].len;
            if (cyc >= due) begin
               chk("done_missing", {31'd0, done}, 32'd1);
               void'(sb.pop_front());
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Holds req for the current cycle; the model decides acceptance from
   // whether the previous transfer's done cycle has been reached.
   task automatic issue(input bit w, input bit l, input logic [4:0] a);
      int   c;
      int   base;
      int   first;
      txn_t t;
      c    = cyc;
      req  = 1'b1;
      we   = w;
      lng  = l;
      addr = a;
      tick();
      req  = 1'b0;
      we   = 1'($urandom);
      lng  = 1'($urandom);
      addr = 5'($urandom);
      if (c >= last_done) begin
         base = int'(a);
         if (l) base = base - (base % 2);
         base    = base * DIG;
         first   = c + 1 + ((base - ((c + 1) % CIRC) + CIRC) % CIRC);
         t.we    = w;
         t.acc   = c;
         t.first = first;
         t.len   = l ? 35 : 17;
         sb.push_back(t);
         last_done = first + t.len;
      end
   endtask

   task automatic wait_pos(input int target);
      for (int i = 0; i < CIRC + 2 && (cyc % CIRC) != target; i++) tick();
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 1500 && sb.size() > 0; i++) tick();
      chk("drain_timeout", sb.size(), 32'd0);
      tick();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      sb.delete();
      last_done = 0;
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst     = 1'b0;
      started = 1'b1;

      // short read, addr 3, requested at minor 0 digit 5
      wait_pos(5);
      issue(1'b0, 1'b0, 5'd3);
      wait_idle();

      // short write at the top address, window ends at the minor wrap
      issue(1'b1, 1'b0, 5'd31);
      wait_idle();

      // long read at odd address 9 behaves as address 8
      issue(1'b0, 1'b1, 5'd9);
      wait_idle();

      // accepted on the edge into minor 6 digit 0: zero wait
      wait_pos(6 * DIG - 1);
      issue(1'b1, 1'b0, 5'd6);
      wait_idle();

      // second request while busy is ignored
      issue(1'b0, 1'b0, 5'd20);
      repeat (30) tick();
      issue(1'b1, 1'b1, 5'd4);
      wait_idle();

      // reset at digit 10 of a long write
      issue(1'b1, 1'b1, 5'd12);
      for (int i = 0; i < 2000 && sb.size() > 0 && cyc != sb[0].first + 10; i++) tick();
      do_reset();
      repeat (40) tick();

      // random traffic, including requests that land while busy
      for (int n = 0; n < 50; n++) begin
         repeat ($urandom_range(0, 650)) tick();
         if ($urandom_range(0, 15) == 0) do_reset();
         issue(1'($urandom), 1'($urandom), 5'($urandom));
      end
      wait_idle();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/memory_r1_up_tank_ctrl.md
# memory_r1_up_tank_ctrl

Gating controller for one upper-bank mercury tank of store rack r1. It sits directly upstream of the tank delay-line stage and drives that stage's `clr`, `in` and `out` gates. It tracks the recirculation position of the tank serially: digit within the minor cycle, and minor cycle within the tank. On an accepted read or write request it opens the gates exactly over the addressed short (17-digit) or long (35-digit) word. Only read and write requests, held in the tank, are handled; arithmetic, order decode and bus multiplexing belong to other blocks.

## Interface
Parameters:
- `DIGITS`, 18: pulse-times per minor cycle. Digits 0..16 are word digits; digit 17 is the spare digit.
- `MINORS`, 32: minor cycles per tank circulation (32 short words = 576 pulse-times = 1.152 ms).

Ports:
- `r1_clk`, in, 1: pulse-time clock.
- `r1_rst`, in, 1: synchronous, active-high reset.
- `r1_up_t0_req`, in, 1: request strobe, sampled every edge.
- `r1_up_t0_we`, in, 1: 1 = write, 0 = read; qualified by `req`.
- `r1_up_t0_long`, in, 1: 1 = long word; qualified by `req`.
- `r1_up_t0_addr`, in, 5: short-word address in the tank; qualified by `req`.
- `r1_up_t0_clr`, out, 1: blocks recirculation in the delay-line stage.
- `r1_up_t0_in`, out, 1: admits `r1_mib` into the tank.
- `r1_up_t0_out`, out, 1: gates the tank output onto `r1_up_mob_t0`.
- `r1_up_t0_busy`, out, 1: a request is armed or in progress.
- `r1_up_t0_done`, out, 1: one-cycle pulse after the last gated digit.
- `r1_up_t0_minor`, out, 5: current minor-cycle count, for the monitor.
- `r1_up_t0_digit`, out, 5: current digit count, for the monitor.

## Operation
- Position counters `digit` (0..17) and `minor` (0..31) are free-running.
  - `digit` wraps 17→0 and then increments `minor`.
  - `minor` wraps 31→0.
  - Reset sets both counters to 0. The delay-line stage is reset on the same edge, so tank position and counters are aligned.
- The state machine has three states.
  - IDLE: `busy`=0. If `req`=1 at an edge, latch `we`, `long` and `addr`, then go to WAIT.
    - For a long request, `addr[0]` is forced to 0, so a long word occupies minor cycles 2k and 2k+1.
  - WAIT: `busy`=1. On the first cycle whose counters equal the window start (`minor`=addr, `digit`=0), go to XFER. That cycle is itself the first gated cycle.
  - XFER: `busy`=1. Gates are active for the window.
    - Short word: digits 0..16 of minor cycle `addr`, 17 cycles.
    - Long word: digit 0 of minor cycle `addr` through digit 16 of minor cycle `addr`+1, 35 cycles including the sandwich digit.
    - On the cycle after the window, `done`=1 and the state returns to IDLE.
- Gate values while in the window:
  - Write: `clr`=1, `in`=1, `out`=0.
  - Read: `out`=1, `clr`=0, `in`=0. The word keeps recirculating.
- All gates are 0 outside the window.
- Requests arriving while `busy`=1 are ignored. They are not queued.
- A request accepted on the edge that moves the counters to the window start is served in that same cycle. Wait time is 0 cycles.

## Timing
- Reset values: `clr`, `in`, `out`, `busy` and `done` are 0; `minor`=0 and `digit`=0; state is IDLE.
- Gates are registered. Each gate is high exactly in the cycles whose `digit`/`minor` values lie inside the window, so they are computed from next-state.
- Latency from acceptance to first gate: 0..575 cycles.
- Latency from acceptance to `done`: short = wait + 17; long = wait + 35.
- A new request may be accepted in the same cycle that `done`=1, because the state is IDLE at that edge.
- Reset asserted mid-transfer takes effect on the next edge: gates drop to 0, the transfer is abandoned, no `done` pulse is issued, and the tank contents for that word are undefined.

## Structure
- A shared package `memory_pkg` holds:
  - constants `DIGITS`, `MINORS` and `WORD_DIGITS`=17;
  - the state enum (IDLE/WAIT/XFER);
  - the request struct {we, long, addr}.
- The natural sub-module is `memory_tank_timer`, the digit/minor position counter. It is reused by every tank controller in the r1 and r2 banks.

## Test plan
- Reset, then a short read at addr 3 accepted at minor 0, digit 5 → `out`=1 for minor 3, digits 0..16; `done` at minor 3, digit 17.
- Short write at addr 31 → `clr`=1 and `in`=1 for 17 cycles at minor 31, digits 0..16; `minor` wraps to 0 afterwards; written data read back identically one circulation later.
- Long read at addr 9 → treated as addr 8; `out`=1 for 35 cycles from minor 8, digit 0 through minor 9, digit 16.
- Request accepted on the edge into minor 6, digit 0, with addr 6 → gates high in that very cycle (zero wait).
- Second `req` while `busy`=1 → no effect; only the first window is gated and exactly one `done` pulse occurs.
- `r1_rst` asserted at digit 10 of a long write → all gates 0 on the next edge; no `done`; counters return to 0/0.
